// File: rtl/pcihellocore_inport.sv
// Avalon-MM input port: synchronizes and debounces an external input bus, captures
// selected edges into a sticky write-1-to-clear register and raises a maskable level irq.
module pcihellocore_inport #(
  parameter int WIDTH        = 32,
  parameter int DEBOUNCE_DIV = 1,
  parameter int EDGE_TYPE    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int               CNT_W   = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_DIV - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [CNT_W-1:0] count;
  logic             tick;
  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] h0, h1;
  logic [WIDTH-1:0] data, prev;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [WIDTH-1:0] stable, edge_evt, clear;
  logic             wr_en;

  assign wr_en = chipselect && !write_n;
  assign tick  = (count == CNT_MAX);

  // A bit is accepted only when the synchronized input and both history samples agree.
  assign stable = ~(sync2 ^ h0) & ~(h0 ^ h1);

  assign edge_evt = (EDGE_TYPE == 0) ? (data & ~prev) :
                    (EDGE_TYPE == 1) ? (~data & prev) :
                                       (data ^ prev);

  assign clear = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      sync1 <= '0;
      sync2 <= '0;
      h0    <= '0;
      h1    <= '0;
      data  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      if (tick) begin
        count <= '0;
        h0    <= sync2;
        h1    <= h0;
        data  <= (data & ~stable) | (sync2 & stable);
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // Set wins over clear so an edge landing on the clearing write is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= data;
      edge_cap <= (edge_cap & ~clear) | edge_evt;
      irq      <= |(edge_cap & irq_mask);
      if (wr_en && address == ADDR_MASK)
        irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(data);
      ADDR_RAW:     readdata = 32'(sync2);
      ADDR_MASK:    readdata = 32'(irq_mask);
      ADDR_EDGECAP: readdata = 32'(edge_cap);
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pcihellocore_inport.sv
// Directed bench for pcihellocore_inport: four instances (any/rising/falling edge at DIV=1,
// any edge at DIV=4) share one bus; each comparison names the instance it reads.
module tb_pcihellocore_inport;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd_any, rd_rise, rd_fall, rd_div4;
  logic        irq_any, irq_rise, irq_fall, irq_div4;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int D_ANY = 0, D_RISE = 1, D_FALL = 2, D_DIV4 = 3;

  pcihellocore_inport #(.WIDTH(32), .DEBOUNCE_DIV(1), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any),
    .in_port(in_port), .irq(irq_any));

  pcihellocore_inport #(.WIDTH(32), .DEBOUNCE_DIV(1), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
    .in_port(in_port), .irq(irq_rise));

  pcihellocore_inport #(.WIDTH(32), .DEBOUNCE_DIV(1), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_fall),
    .in_port(in_port), .irq(irq_fall));

  pcihellocore_inport #(.WIDTH(32), .DEBOUNCE_DIV(4), .EDGE_TYPE(2)) u_div4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_div4),
    .in_port(in_port), .irq(irq_div4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input int dut, input logic [1:0] a,
                         input logic [31:0] exp);
    logic [31:0] v;
    address = a;
    #1;
    case (dut)
      D_ANY:   v = rd_any;
      D_RISE:  v = rd_rise;
      D_FALL:  v = rd_fall;
      default: v = rd_div4;
    endcase
    check(tag, v, exp);
  endtask

  // Write lands on the next rising edge; returns 1 ns after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Reset pulse released between edges; the next edge is the first after release.
  task automatic reset_all();
    in_port = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    #12;
    reset_all();

    // Reset state
    check("rst_irq", {31'b0, irq_any}, 32'h0);
    chk_reg("rst_data",    D_ANY, 2'd0, 32'h0);
    chk_reg("rst_raw",     D_ANY, 2'd1, 32'h0);
    chk_reg("rst_mask",    D_ANY, 2'd2, 32'h0);
    chk_reg("rst_edgecap", D_ANY, 2'd3, 32'h0);

    // Two-cycle glitch on bit0 must not reach DATA
    tick(2);
    in_port = 32'h1;
    tick(2);
    chk_reg("glitch_raw_hi", D_ANY, 2'd1, 32'h1);
    in_port = 32'h0;
    tick(6);
    chk_reg("glitch_data",    D_ANY, 2'd0, 32'h0);
    chk_reg("glitch_edgecap", D_ANY, 2'd3, 32'h0);
    chk_reg("glitch_raw_lo",  D_ANY, 2'd1, 32'h0);

    // Held bit0 with IRQMASK=1: DATA at k+4, EDGECAP at k+5, irq at k+6
    wr(2'd2, 32'h1);
    in_port = 32'h1;
    tick(4);
    chk_reg("hold_data_k3", D_ANY, 2'd0, 32'h0);
    tick(1);
    chk_reg("hold_data_k4", D_ANY, 2'd0, 32'h1);
    chk_reg("hold_ec_k4",   D_ANY, 2'd3, 32'h0);
    tick(1);
    chk_reg("hold_ec_k5",   D_ANY, 2'd3, 32'h1);
    check("irq_k5", {31'b0, irq_any}, 32'h0);
    tick(1);
    check("irq_k6", {31'b0, irq_any}, 32'h1);

    // W1C clear: EDGECAP drops at m, irq one edge later
    wr(2'd3, 32'h1);
    chk_reg("clr_edgecap", D_ANY, 2'd3, 32'h0);
    check("clr_irq_m", {31'b0, irq_any}, 32'h1);
    tick(1);
    check("clr_irq_m1", {31'b0, irq_any}, 32'h0);

    // Unmasked capture keeps irq low; mask change then raises it at m+1
    wr(2'd2, 32'h2);
    in_port = 32'h0;
    tick(8);
    chk_reg("mask2_edgecap", D_ANY, 2'd3, 32'h1);
    check("mask2_irq", {31'b0, irq_any}, 32'h0);
    wr(2'd2, 32'h1);
    check("mask1_irq_m", {31'b0, irq_any}, 32'h0);
    tick(1);
    check("mask1_irq_m1", {31'b0, irq_any}, 32'h1);
    chk_reg("mask1_edgecap", D_ANY, 2'd3, 32'h1);

    // Set/clear collision on bit2
    wr(2'd2, 32'h4);
    in_port = 32'h4;
    tick(5);
    wr(2'd3, 32'h4);
    chk_reg("coll_edgecap", D_ANY, 2'd3, 32'h5);
    check("coll_irq_m", {31'b0, irq_any}, 32'h0);
    tick(1);
    check("coll_irq_m1", {31'b0, irq_any}, 32'h1);

    // Writes to read-only addresses are ignored
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    chk_reg("ro_data", D_ANY, 2'd0, 32'h4);
    chk_reg("ro_raw",  D_ANY, 2'd1, 32'h4);

    // Rising vs falling capture on bit3
    reset_all();
    tick(2);
    in_port = 32'h8;
    tick(8);
    chk_reg("rise_ec_up",   D_RISE, 2'd3, 32'h8);
    chk_reg("fall_ec_up",   D_FALL, 2'd3, 32'h0);
    chk_reg("rise_data_up", D_RISE, 2'd0, 32'h8);
    chk_reg("fall_data_up", D_FALL, 2'd0, 32'h8);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0;
    tick(8);
    chk_reg("rise_ec_dn",   D_RISE, 2'd3, 32'h0);
    chk_reg("fall_ec_dn",   D_FALL, 2'd3, 32'h8);
    chk_reg("rise_data_dn", D_RISE, 2'd0, 32'h0);
    chk_reg("fall_data_dn", D_FALL, 2'd0, 32'h0);
    chk_reg("any_ec_dn",    D_ANY,  2'd3, 32'h8);

    // DIV=4: ticks on edges 4,8,12,... after release. An 11-cycle level spans only
    // ticks 8 and 12; a held level seen from edge 36 is accepted on tick 44.
    reset_all();
    tick(2);
    in_port = 32'h10;
    tick(11);
    in_port = 32'h0;
    tick(20);
    chk_reg("div4_short_data", D_DIV4, 2'd0, 32'h0);
    chk_reg("div4_short_ec",   D_DIV4, 2'd3, 32'h0);
    in_port = 32'h10;
    tick(10);
    chk_reg("div4_data_e43", D_DIV4, 2'd0, 32'h0);
    tick(1);
    chk_reg("div4_data_e44", D_DIV4, 2'd0, 32'h10);
    tick(1);
    chk_reg("div4_ec_e45",   D_DIV4, 2'd3, 32'h10);

    // Mid-cycle reset with all inputs high, then re-capture after release
    wr(2'd2, 32'hFFFF_FFFF);
    in_port = 32'hFFFF_FFFF;
    tick(10);
    check("pre_rst_irq", {31'b0, irq_any}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_irq", {31'b0, irq_any}, 32'h0);
    chk_reg("mid_rst_data", D_ANY, 2'd0, 32'h0);
    chk_reg("mid_rst_raw",  D_ANY, 2'd1, 32'h0);
    chk_reg("mid_rst_mask", D_ANY, 2'd2, 32'h0);
    chk_reg("mid_rst_ec",   D_ANY, 2'd3, 32'h0);
    reset = 1'b0;
    tick(4);
    chk_reg("rel_data_k3", D_ANY, 2'd0, 32'h0);
    tick(1);
    chk_reg("rel_data_k4", D_ANY, 2'd0, 32'hFFFF_FFFF);
    chk_reg("rel_ec_k4",   D_ANY, 2'd3, 32'h0);
    tick(1);
    chk_reg("rel_ec_k5",   D_ANY, 2'd3, 32'hFFFF_FFFF);
    check("rel_irq", {31'b0, irq_any}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
